// File: rtl/user_mem_responder.sv
// user_mem_responder
// ------------------
// Responder end of the user-circuit memory/register interface. Holds the
// input memory (host loads, user reads), the output memory (user writes,
// host reads), the 32-bit parameter register file and the run flag.
//
// Build option: define RESP_STALL_EN to insert 0-3 pseudo-random wait cycles
// (8-bit LFSR) between a request and its acknowledge on every channel. When it
// is undefined, Ack always follows Req by exactly one cycle.
//
// Handshake (register, input-read and output-write channels alike):
//   The user raises Req and holds address/data stable. The responder answers
//   with a single-cycle Ack pulse. The transfer is accepted in the cycle where
//   Req && Ack are both high; all request fields are captured in that cycle.
//   If Req falls before Ack arrives, the Ack still pulses (or, with stalls,
//   the wait is abandoned), but nothing is accepted.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   userRunValue/Clear, hostRunSet run flag (set wins over clear)
//   register32*                    user register channel, read returns 1 cycle after acceptance
//   inputMemoryRead*               user input-memory read, returns READ_LATENCY cycles after acceptance
//   outputMemoryWrite*             user output-memory byte-masked write
//   hostIn*                        host load port of the input memory
//   hostOut*                       host read port of the output memory (1-cycle return)
//   hostReg*                       host write port of the register file
//   debug_state                    {out, in, reg} handshake FSM states

module user_mem_responder_hs (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] stall_cycles,
    output logic       ack,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_WAIT = 2'd1,
        HS_ACK  = 2'd2
    } hs_state_t;

    hs_state_t  state;
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HS_IDLE;
            ack   <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                HS_IDLE: begin
                    if (req) begin
                        if (stall_cycles == 2'd0) begin
                            state <= HS_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= HS_WAIT;
                            cnt   <= stall_cycles;
                        end
                    end
                end
                HS_WAIT: begin
                    // Abandon the wait if the requester gives up.
                    if (!req) begin
                        state <= HS_IDLE;
                    end else if (cnt == 2'd1) begin
                        state <= HS_ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                HS_ACK: begin
                    // Always return to idle so Ack is never high twice in a row.
                    state <= HS_IDLE;
                end
                default: begin
                    state <= HS_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;
endmodule

module user_mem_responder #(
    parameter int INMEM_BYTE_WIDTH     = 4,
    parameter int OUTMEM_BYTE_WIDTH    = 4,
    parameter int INMEM_ADDRESS_WIDTH  = 17,
    parameter int OUTMEM_ADDRESS_WIDTH = 13,
    parameter int NUM_REGS             = 16,
    parameter int READ_LATENCY         = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              userRunValue,
    input  logic                              userRunClear,
    input  logic                              hostRunSet,
    input  logic                              register32CmdReq,
    output logic                              register32CmdAck,
    input  logic                              register32WriteEn,
    input  logic [7:0]                        register32Address,
    input  logic [31:0]                       register32WriteData,
    output logic                              register32ReadDataValid,
    output logic [31:0]                       register32ReadData,
    input  logic                              inputMemoryReadReq,
    output logic                              inputMemoryReadAck,
    input  logic [INMEM_ADDRESS_WIDTH-1:0]    inputMemoryReadAdd,
    output logic                              inputMemoryReadDataValid,
    output logic [INMEM_BYTE_WIDTH*8-1:0]     inputMemoryReadData,
    input  logic                              outputMemoryWriteReq,
    output logic                              outputMemoryWriteAck,
    input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   outputMemoryWriteAdd,
    input  logic [OUTMEM_BYTE_WIDTH*8-1:0]    outputMemoryWriteData,
    input  logic [OUTMEM_BYTE_WIDTH-1:0]      outputMemoryWriteByteMask,
    input  logic                              hostInWe,
    input  logic [INMEM_ADDRESS_WIDTH-1:0]    hostInAdd,
    input  logic [INMEM_BYTE_WIDTH*8-1:0]     hostInData,
    input  logic                              hostOutRe,
    input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   hostOutAdd,
    output logic                              hostOutValid,
    output logic [OUTMEM_BYTE_WIDTH*8-1:0]    hostOutData,
    input  logic                              hostRegWe,
    input  logic [7:0]                        hostRegAddr,
    input  logic [31:0]                       hostRegData,
    output logic [5:0]                        debug_state
);
    localparam int IW  = INMEM_BYTE_WIDTH * 8;
    localparam int OW  = OUTMEM_BYTE_WIDTH * 8;
    localparam int RIW = $clog2(NUM_REGS);

    // ---------------------------------------------------------------- stalls
    logic [1:0] stall_cycles;

`ifdef RESP_STALL_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall_cycles = lfsr[1:0];
`else
    assign stall_cycles = 2'b00;
`endif

    // ------------------------------------------------------------ handshakes
    logic [1:0] reg_state, in_state, out_state;

    user_mem_responder_hs u_reg_hs (
        .clk          (clk),
        .reset        (reset),
        .req          (register32CmdReq),
        .stall_cycles (stall_cycles),
        .ack          (register32CmdAck),
        .state_dbg    (reg_state)
    );

    user_mem_responder_hs u_in_hs (
        .clk          (clk),
        .reset        (reset),
        .req          (inputMemoryReadReq),
        .stall_cycles (stall_cycles),
        .ack          (inputMemoryReadAck),
        .state_dbg    (in_state)
    );

    user_mem_responder_hs u_out_hs (
        .clk          (clk),
        .reset        (reset),
        .req          (outputMemoryWriteReq),
        .stall_cycles (stall_cycles),
        .ack          (outputMemoryWriteAck),
        .state_dbg    (out_state)
    );

    assign debug_state = {out_state, in_state, reg_state};

    logic reg_accept, in_accept, out_accept;

    assign reg_accept = register32CmdReq     && register32CmdAck     && !reset;
    assign in_accept  = inputMemoryReadReq   && inputMemoryReadAck   && !reset;
    assign out_accept = outputMemoryWriteReq && outputMemoryWriteAck && !reset;

    // ---------------------------------------------------------- input memory
    logic [IW-1:0] inmem [0:(1 << INMEM_ADDRESS_WIDTH)-1];
    logic [IW-1:0] rd_raw;
    logic [IW-1:0] rd_out;
    logic [READ_LATENCY-1:0] rd_vld;

    // Read-before-write: a same-address host load returns the old word.
    always_ff @(posedge clk) begin
        if (hostInWe) begin
            inmem[hostInAdd] <= hostInData;
        end
        if (in_accept) begin
            rd_raw <= inmem[inputMemoryReadAdd];
        end
    end

    // Valid shift register; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= in_accept;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_vld[k] <= rd_vld[k-1];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rd_out = rd_raw;
        end else begin : g_latn
            logic [IW-1:0] rd_pipe [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                rd_pipe[0] <= rd_raw;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    rd_pipe[k] <= rd_pipe[k-1];
                end
            end

            assign rd_out = rd_pipe[READ_LATENCY-2];
        end
    endgenerate

    assign inputMemoryReadDataValid = rd_vld[READ_LATENCY-1];
    assign inputMemoryReadData      = rd_vld[READ_LATENCY-1] ? rd_out : '0;

    // --------------------------------------------------------- output memory
    logic [OW-1:0] outmem [0:(1 << OUTMEM_ADDRESS_WIDTH)-1];
    logic [OW-1:0] host_out_raw;

    // Read-before-write: a same-address user write is not seen by the host read.
    always_ff @(posedge clk) begin
        for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++) begin
            if (out_accept && outputMemoryWriteByteMask[b]) begin
                outmem[outputMemoryWriteAdd][b*8 +: 8] <= outputMemoryWriteData[b*8 +: 8];
            end
        end
        if (hostOutRe) begin
            host_out_raw <= outmem[hostOutAdd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hostOutValid <= 1'b0;
        end else begin
            hostOutValid <= hostOutRe;
        end
    end

    assign hostOutData = hostOutValid ? host_out_raw : '0;

    // --------------------------------------------------------- register file
    logic [31:0] regs [NUM_REGS];
    logic        user_reg_hit, host_reg_hit;

    assign user_reg_hit = ({24'd0, register32Address} < 32'(NUM_REGS));
    assign host_reg_hit = ({24'd0, hostRegAddr}       < 32'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            register32ReadDataValid <= 1'b0;
            register32ReadData      <= '0;
        end else begin
            register32ReadDataValid <= reg_accept && !register32WriteEn;
            register32ReadData      <= (reg_accept && !register32WriteEn && user_reg_hit)
                                       ? regs[register32Address[RIW-1:0]] : '0;
            if (reg_accept && register32WriteEn && user_reg_hit) begin
                regs[register32Address[RIW-1:0]] <= register32WriteData;
            end
            // Host write comes last so it wins a same-register collision.
            if (hostRegWe && host_reg_hit) begin
                regs[hostRegAddr[RIW-1:0]] <= hostRegData;
            end
        end
    end

    // -------------------------------------------------------------- run flag
    always_ff @(posedge clk) begin
        if (reset) begin
            userRunValue <= 1'b0;
        end else if (hostRunSet) begin
            userRunValue <= 1'b1;
        end else if (userRunClear) begin
            userRunValue <= 1'b0;
        end
    end
endmodule

// File: tb/tb_user_mem_responder.sv
// Testbench for user_mem_responder (default build, stalls disabled).
// A behavioural model advances once per clock inside step() and every output
// is compared against it; directed sequences and tables add explicit checks.

module tb_user_mem_responder;
    localparam int L  = 2;
    localparam int NR = 16;

    // ------------------------------------------------- clock / reset block
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        userRunValue, userRunClear, hostRunSet;
    logic        register32CmdReq, register32CmdAck, register32WriteEn;
    logic [7:0]  register32Address;
    logic [31:0] register32WriteData;
    logic        register32ReadDataValid;
    logic [31:0] register32ReadData;
    logic        inputMemoryReadReq, inputMemoryReadAck;
    logic [16:0] inputMemoryReadAdd;
    logic        inputMemoryReadDataValid;
    logic [31:0] inputMemoryReadData;
    logic        outputMemoryWriteReq, outputMemoryWriteAck;
    logic [12:0] outputMemoryWriteAdd;
    logic [31:0] outputMemoryWriteData;
    logic [3:0]  outputMemoryWriteByteMask;
    logic        hostInWe;
    logic [16:0] hostInAdd;
    logic [31:0] hostInData;
    logic        hostOutRe;
    logic [12:0] hostOutAdd;
    logic        hostOutValid;
    logic [31:0] hostOutData;
    logic        hostRegWe;
    logic [7:0]  hostRegAddr;
    logic [31:0] hostRegData;
    logic [5:0]  debug_state;

    user_mem_responder #(.READ_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .userRunValue(userRunValue), .userRunClear(userRunClear), .hostRunSet(hostRunSet),
        .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
        .register32WriteEn(register32WriteEn), .register32Address(register32Address),
        .register32WriteData(register32WriteData),
        .register32ReadDataValid(register32ReadDataValid), .register32ReadData(register32ReadData),
        .inputMemoryReadReq(inputMemoryReadReq), .inputMemoryReadAck(inputMemoryReadAck),
        .inputMemoryReadAdd(inputMemoryReadAdd),
        .inputMemoryReadDataValid(inputMemoryReadDataValid), .inputMemoryReadData(inputMemoryReadData),
        .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
        .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
        .outputMemoryWriteByteMask(outputMemoryWriteByteMask),
        .hostInWe(hostInWe), .hostInAdd(hostInAdd), .hostInData(hostInData),
        .hostOutRe(hostOutRe), .hostOutAdd(hostOutAdd),
        .hostOutValid(hostOutValid), .hostOutData(hostOutData),
        .hostRegWe(hostRegWe), .hostRegAddr(hostRegAddr), .hostRegData(hostRegData),
        .debug_state(debug_state)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // ---------------------------------------------------------- scoreboard
    bit          ack_m [3];          // 0 = register, 1 = input read, 2 = output write
    logic [31:0] regs_m [NR];
    bit          run_m;
    logic [31:0] inm  [int];
    logic [31:0] outm [int];
    logic [31:0] exp_q [$];          // expected input-read return data
    int          due_q [$];          // cycle on which each return is due

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample held inputs, advance, update model, compare everything.
    task automatic step();
        logic        h_rst, h_we, h_iwe, h_ore, h_hre, h_set, h_clr;
        logic        h_req [3];
        logic [7:0]  h_ra, h_hra;
        logic [31:0] h_rwd, h_hrd, h_idata, h_odata, tmp;
        logic [16:0] h_iadd, h_radd;
        logic [12:0] h_oadd, h_hoadd;
        logic [3:0]  h_mask;
        bit          acc [3];
        bit          ack_e [3];
        bit          rv_e, hov_e, iv_e;
        logic [31:0] rd_e, hod_e, id_e;

        h_rst = reset;  h_we = register32WriteEn; h_ra = register32Address; h_rwd = register32WriteData;
        h_req[0] = register32CmdReq; h_req[1] = inputMemoryReadReq; h_req[2] = outputMemoryWriteReq;
        h_radd = inputMemoryReadAdd; h_oadd = outputMemoryWriteAdd; h_odata = outputMemoryWriteData;
        h_mask = outputMemoryWriteByteMask; h_iwe = hostInWe; h_iadd = hostInAdd; h_idata = hostInData;
        h_ore = hostOutRe; h_hoadd = hostOutAdd; h_hre = hostRegWe; h_hra = hostRegAddr;
        h_hrd = hostRegData; h_set = hostRunSet; h_clr = userRunClear;

        @(posedge clk);
        #1;
        cyc++;

        rv_e = 0; rd_e = '0; hov_e = 0; hod_e = '0;
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0;
            ack_e[i] = 0;
        end
        if (h_rst) begin
            exp_q.delete();
            due_q.delete();
            for (int k = 0; k < NR; k++) regs_m[k] = '0;
            run_m = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                acc[i]   = h_req[i] && ack_m[i];
                ack_e[i] = h_req[i] && !ack_m[i];
            end
            if (acc[1]) begin
                exp_q.push_back(inm[int'(h_radd)]);
                due_q.push_back(cyc + L - 1);
            end
            rv_e  = acc[0] && !h_we;
            rd_e  = (rv_e && h_ra < NR) ? regs_m[h_ra] : 32'h0;
            hov_e = h_ore;
            hod_e = h_ore ? outm[int'(h_hoadd)] : 32'h0;
            if (h_set) run_m = 1;
            else if (h_clr) run_m = 0;
            if (acc[0] && h_we && h_ra < NR) regs_m[h_ra] = h_rwd;
            if (h_hre && h_hra < NR) regs_m[h_hra] = h_hrd;
            if (acc[2]) begin
                tmp = outm.exists(int'(h_oadd)) ? outm[int'(h_oadd)] : 32'h0;
                for (int b = 0; b < 4; b++) if (h_mask[b]) tmp[b*8 +: 8] = h_odata[b*8 +: 8];
                outm[int'(h_oadd)] = tmp;
            end
        end
        if (h_iwe) inm[int'(h_iadd)] = h_idata;
        ack_m = ack_e;

        iv_e = (due_q.size() > 0) && (due_q[0] == cyc);
        id_e = iv_e ? exp_q[0] : 32'h0;
        if (iv_e) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end

        chk("reg_ack",   register32CmdAck,         ack_e[0]);
        chk("in_ack",    inputMemoryReadAck,       ack_e[1]);
        chk("out_ack",   outputMemoryWriteAck,     ack_e[2]);
        chk("reg_valid", register32ReadDataValid,  rv_e);
        chk("reg_data",  register32ReadData,       rd_e);
        chk("in_valid",  inputMemoryReadDataValid, iv_e);
        chk("in_data",   inputMemoryReadData,      id_e);
        chk("host_valid", hostOutValid,            hov_e);
        chk("host_data", hostOutData,              hod_e);
        chk("run",       userRunValue,             run_m);
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic idle_inputs();
        userRunClear = 0; hostRunSet = 0;
        register32CmdReq = 0; register32WriteEn = 0; register32Address = 0; register32WriteData = 0;
        inputMemoryReadReq = 0; inputMemoryReadAdd = 0;
        outputMemoryWriteReq = 0; outputMemoryWriteAdd = 0; outputMemoryWriteData = 0;
        outputMemoryWriteByteMask = 0;
        hostInWe = 0; hostInAdd = 0; hostInData = 0;
        hostOutRe = 0; hostOutAdd = 0;
        hostRegWe = 0; hostRegAddr = 0; hostRegData = 0;
    endtask

    task automatic host_load(input int a, input logic [31:0] d);
        hostInWe = 1; hostInAdd = 17'(a); hostInData = d;
        step();
        hostInWe = 0;
    endtask

    task automatic out_write(input int a, input logic [31:0] d, input logic [3:0] m);
        outputMemoryWriteReq = 1; outputMemoryWriteAdd = 13'(a);
        outputMemoryWriteData = d; outputMemoryWriteByteMask = m;
        step();
        step();
        outputMemoryWriteReq = 0;
    endtask

    task automatic host_read(input int a, output logic [31:0] d);
        hostOutRe = 1; hostOutAdd = 13'(a);
        step();
        hostOutRe = 0;
        d = hostOutData;
    endtask

    // Req held through the Ack cycle; lat counts cycles from acceptance.
    task automatic in_read(input int a, output logic [31:0] d, output int lat, output int pulses);
        inputMemoryReadReq = 1; inputMemoryReadAdd = 17'(a);
        step();
        chk("in_ack_next_cycle", inputMemoryReadAck, 1);
        step();
        inputMemoryReadReq = 0;
        pulses = 0; lat = -1; d = '0;
        for (int i = 0; i < L + 3; i++) begin
            if (inputMemoryReadDataValid) begin
                pulses++;
                if (lat < 0) lat = i + 1;
                d = inputMemoryReadData;
            end
            step();
        end
    endtask

    task automatic reg_op(input bit we, input logic [7:0] a, input logic [31:0] wd,
                          output bit vld, output logic [31:0] rd);
        register32CmdReq = 1; register32WriteEn = we; register32Address = a; register32WriteData = wd;
        step();
        step();
        register32CmdReq = 0;
        vld = register32ReadDataValid;
        rd  = register32ReadData;
    endtask

    // ---------------------------------------------------------------- test
    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        bit set;
        bit clr;
        bit exp;
    } run_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    rv [10];
        run_vec_t    runv [9];
        logic [31:0] pre_in [16];
        logic [31:0] d;
        logic [31:0] got [$];
        int          lat, pulses, issued;
        bit          vld, ack_prev;

        rv[0] = '{0, 8'd0,   32'h0,        32'h00000001};
        rv[1] = '{0, 8'd200, 32'h0,        32'h0};
        rv[2] = '{1, 8'd3,   32'hCAFEF00D, 32'h0};
        rv[3] = '{0, 8'd3,   32'h0,        32'hCAFEF00D};
        rv[4] = '{1, 8'd20,  32'h12345678, 32'h0};
        rv[5] = '{0, 8'd20,  32'h0,        32'h0};
        rv[6] = '{0, 8'd4,   32'h0,        32'h0};
        rv[7] = '{1, 8'd15,  32'hFFFFFFFF, 32'h0};
        rv[8] = '{0, 8'd15,  32'h0,        32'hFFFFFFFF};
        rv[9] = '{0, 8'd16,  32'h0,        32'h0};

        runv[0] = '{1, 1, 1};
        runv[1] = '{0, 1, 0};
        runv[2] = '{0, 0, 0};
        runv[3] = '{1, 0, 1};
        runv[4] = '{0, 0, 1};
        runv[5] = '{0, 1, 0};
        runv[6] = '{1, 1, 1};
        runv[7] = '{0, 0, 1};
        runv[8] = '{0, 1, 0};

        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("rst_run", userRunValue, 0);
        chk("rst_acks", {register32CmdAck, inputMemoryReadAck, outputMemoryWriteAck}, 0);
        chk("rst_valids", {register32ReadDataValid, inputMemoryReadDataValid, hostOutValid}, 0);

        // Preload both memories over the address window used below.
        for (int a = 0; a < 16; a++) begin
            pre_in[a] = (a == 5) ? 32'hDEADBEEF : $urandom;
            host_load(a, pre_in[a]);
        end
        for (int a = 0; a < 16; a++) out_write(a, $urandom, 4'hF);

        // Single read of the DEADBEEF word.
        in_read(5, d, lat, pulses);
        chk("rd5_data", d, 32'hDEADBEEF);
        chk("rd5_latency", lat, L);
        chk("rd5_pulses", pulses, 1);

        // Back-to-back reads of 0,1,2 with Req held continuously.
        inputMemoryReadReq = 1; inputMemoryReadAdd = 0; issued = 0; ack_prev = 0;
        for (int i = 0; i < 40 && (issued < 3 || got.size() < 3); i++) begin
            step();
            if (inputMemoryReadDataValid) got.push_back(inputMemoryReadData);
            if (ack_prev) begin
                issued++;
                if (issued < 3) inputMemoryReadAdd = 17'(issued);
                else inputMemoryReadReq = 0;
            end
            ack_prev = inputMemoryReadAck;
        end
        inputMemoryReadReq = 0;
        chk("b2b_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("b2b_data", got[i], pre_in[i]);

        // Req dropped before Ack: Ack still pulses, nothing returns.
        inputMemoryReadReq = 1; inputMemoryReadAdd = 9;
        step();
        inputMemoryReadReq = 0;
        chk("drop_ack", inputMemoryReadAck, 1);
        pulses = 0;
        for (int i = 0; i < L + 3; i++) begin
            step();
            if (inputMemoryReadDataValid) pulses++;
        end
        chk("drop_no_return", pulses, 0);

        // Byte-masked output write.
        out_write(3, 32'h11223344, 4'hF);
        out_write(3, 32'hAABBCCDD, 4'b0101);
        host_read(3, d);
        chk("mask_write", d, 32'h11BB33DD);

        // Register table.
        hostRegWe = 1; hostRegAddr = 0; hostRegData = 32'h1;
        step();
        hostRegWe = 0;
        foreach (rv[i]) begin
            reg_op(rv[i].we, rv[i].addr, rv[i].wdata, vld, d);
            chk("reg_tbl_valid", vld, !rv[i].we);
            if (!rv[i].we) chk("reg_tbl_data", d, rv[i].exp);
        end

        // Host and user write register 6 in the acceptance cycle: host wins.
        register32CmdReq = 1; register32WriteEn = 1; register32Address = 6; register32WriteData = 32'h1111;
        step();
        hostRegWe = 1; hostRegAddr = 6; hostRegData = 32'h2222;
        step();
        hostRegWe = 0; register32CmdReq = 0;
        reg_op(0, 8'd6, 32'h0, vld, d);
        chk("reg_collision", d, 32'h2222);

        // Run flag table.
        foreach (runv[i]) begin
            hostRunSet = runv[i].set; userRunClear = runv[i].clr;
            step();
            chk("run_tbl", userRunValue, runv[i].exp);
        end
        hostRunSet = 0; userRunClear = 0;

        // Reset one cycle after a read acceptance discards the return.
        hostRunSet = 1;
        step();
        hostRunSet = 0;
        inputMemoryReadReq = 1; inputMemoryReadAdd = 7;
        step();
        step();
        inputMemoryReadReq = 0;
        reset = 1;
        step();
        reset = 0;
        chk("rst_mid_run", userRunValue, 0);
        pulses = 0;
        for (int i = 0; i < L + 3; i++) begin
            if (inputMemoryReadDataValid || register32ReadDataValid) pulses++;
            step();
        end
        chk("rst_mid_no_return", pulses, 0);

        // Randomized traffic on every port against the model.
        for (int i = 0; i < 400; i++) begin
            register32CmdReq     = ($urandom_range(0, 3) != 0);
            register32WriteEn    = $urandom_range(0, 1);
            register32Address    = 8'($urandom_range(0, 20));
            register32WriteData  = $urandom;
            inputMemoryReadReq   = ($urandom_range(0, 3) != 0);
            inputMemoryReadAdd   = 17'($urandom_range(0, 15));
            outputMemoryWriteReq = ($urandom_range(0, 3) != 0);
            outputMemoryWriteAdd = 13'($urandom_range(0, 15));
            outputMemoryWriteData = $urandom;
            outputMemoryWriteByteMask = 4'($urandom_range(0, 15));
            hostInWe   = ($urandom_range(0, 3) == 0);
            hostInAdd  = 17'($urandom_range(0, 15));
            hostInData = $urandom;
            hostOutRe  = $urandom_range(0, 1);
            hostOutAdd = 13'($urandom_range(0, 15));
            hostRegWe  = ($urandom_range(0, 3) == 0);
            hostRegAddr = 8'($urandom_range(0, 20));
            hostRegData = $urandom;
            hostRunSet   = ($urandom_range(0, 7) == 0);
            userRunClear = ($urandom_range(0, 7) == 0);
            step();
        end
        idle_inputs();
        for (int i = 0; i < L + 4; i++) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
